// File: rtl/fsm_req_arbiter_pkg.sv
// Shared definitions for the control-FSM request arbiter.
// Contents: default field widths, opcode constants, output channel state
// type and the packed layout of one forwarded mem request.
package fsm_req_arbiter_pkg;

    localparam int DEF_NUM_FSM  = 4;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_WIDTH_W  = 3;
    localparam int DEF_OPCODE_W = 2;
    localparam int DEF_SRC_ID_W = 4;

    localparam logic [DEF_OPCODE_W-1:0] MEM_OPCODE_READ         = 2'd0;
    localparam logic [DEF_OPCODE_W-1:0] MEM_OPCODE_WRITE_ADDR   = 2'd1;
    localparam logic [DEF_OPCODE_W-1:0] ACCEL_OPCODE_WRITE_DATA = 2'd2;

    // Output channel register: empty, or holding one request until out_ready.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    // Field order of one internal request as carried on the mem channel.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_WIDTH_W-1:0]  width;
        logic [DEF_OPCODE_W-1:0] opcode;
        logic [DEF_SRC_ID_W-1:0] source_id;
    } internal_req_t;

endpackage

// File: rtl/fsm_req_arbiter_if.sv
// Bundle of all request, downstream and response signals of fsm_req_arbiter.
// Modports: slave = arbiter view, master = control-FSM / NoC (bench) view.
// Handshake: a downstream channel holds out_valid with a stable payload
// until out_ready is seen high at a clock edge; the transfer happens on that
// edge (valid & ready). fsm_req_valid is a level and may stay high; arb_won
// and ack are single-cycle pulses. When FSM_ARB_TIMEOUT_EN is defined an
// extra per-FSM timeout pulse output is present.
interface fsm_req_arbiter_if
    import fsm_req_arbiter_pkg::*;
#(
    parameter int NUM_FSM  = DEF_NUM_FSM,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WIDTH_W  = DEF_WIDTH_W,
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int SRC_ID_W = DEF_SRC_ID_W
);
    logic [NUM_FSM-1:0]          fsm_req_valid;
    logic [NUM_FSM-1:0]          fsm_req_is_mem;
    logic [NUM_FSM*ADDR_W-1:0]   fsm_req_addr;
    logic [NUM_FSM*WIDTH_W-1:0]  fsm_req_width;
    logic [NUM_FSM*OPCODE_W-1:0] fsm_req_opcode;
    logic [NUM_FSM*SRC_ID_W-1:0] fsm_req_source_id;
    logic [NUM_FSM-1:0]          arb_won;
    logic [NUM_FSM-1:0]          ack;
    logic                        mem_out_valid;
    logic                        mem_out_ready;
    logic [ADDR_W-1:0]           mem_out_addr;
    logic [WIDTH_W-1:0]          mem_out_width;
    logic [OPCODE_W-1:0]         mem_out_opcode;
    logic [SRC_ID_W-1:0]         mem_out_source_id;
    logic                        accel_out_valid;
    logic                        accel_out_ready;
    logic [OPCODE_W-1:0]         accel_out_opcode;
    logic [SRC_ID_W-1:0]         accel_out_source_id;
    logic                        resp_valid;
    logic [SRC_ID_W-1:0]         resp_source_id;
    logic                        unmatched_resp;
    ch_state_e                   mem_ch_state;
    ch_state_e                   accel_ch_state;
`ifdef FSM_ARB_TIMEOUT_EN
    logic [NUM_FSM-1:0]          timeout;
`endif

    modport slave (
`ifdef FSM_ARB_TIMEOUT_EN
        output timeout,
`endif
        input  fsm_req_valid, fsm_req_is_mem, fsm_req_addr, fsm_req_width,
               fsm_req_opcode, fsm_req_source_id, mem_out_ready, accel_out_ready,
               resp_valid, resp_source_id,
        output arb_won, ack, mem_out_valid, mem_out_addr, mem_out_width,
               mem_out_opcode, mem_out_source_id, accel_out_valid,
               accel_out_opcode, accel_out_source_id, unmatched_resp,
               mem_ch_state, accel_ch_state
    );

    modport master (
`ifdef FSM_ARB_TIMEOUT_EN
        input  timeout,
`endif
        output fsm_req_valid, fsm_req_is_mem, fsm_req_addr, fsm_req_width,
               fsm_req_opcode, fsm_req_source_id, mem_out_ready, accel_out_ready,
               resp_valid, resp_source_id,
        input  arb_won, ack, mem_out_valid, mem_out_addr, mem_out_width,
               mem_out_opcode, mem_out_source_id, accel_out_valid,
               accel_out_opcode, accel_out_source_id, unmatched_resp,
               mem_ch_state, accel_ch_state
    );
endinterface

// File: rtl/fsm_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker for one channel.
// Ports: req_i (eligible mask), ptr_i (first index to consider),
// gnt_o (one-hot grant), gnt_valid_o, gnt_idx_o (granted index),
// ptr_next_o (index after the winner, wraps since NUM_FSM is a power of two).
module fsm_req_arbiter_rr_arbiter #(
    parameter int NUM_FSM = 4,
    localparam int PTR_W  = $clog2(NUM_FSM)
) (
    input  logic [NUM_FSM-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_FSM-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic [PTR_W-1:0]   ptr_next_o
);
    logic             found;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] win;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = '0;
        for (int i = 0; i < NUM_FSM; i++) begin
            // Index arithmetic wraps naturally at PTR_W bits.
            cand = ptr_i + PTR_W'(i);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign gnt_valid_o = found;
    assign gnt_idx_o   = win;
    assign gnt_o       = found ? (NUM_FSM'(1) << win) : '0;
    assign ptr_next_o  = win + PTR_W'(1);
endmodule

// File: rtl/fsm_req_arbiter.sv
// Responder for the control-FSM request interface: grants one request per
// cycle per channel (mem, accel) round-robin, forwards it downstream, pulses
// arb_won to the winner and later ack when a response with its source_id
// returns. Unmatched responses set a sticky unmatched_resp flag.
// Ports: clk, rst (async active-high), bus (fsm_req_arbiter_if.slave).
// Optional macro FSM_ARB_TIMEOUT_EN: per-FSM response timeout counters that
// clear an outstanding request after TIMEOUT_CYCLES and pulse bus.timeout.
module fsm_req_arbiter
    import fsm_req_arbiter_pkg::*;
#(
    parameter int NUM_FSM     = DEF_NUM_FSM,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int OPCODE_W    = DEF_OPCODE_W,
    parameter int SRC_ID_W    = DEF_SRC_ID_W,
    parameter int BASE_SRC_ID = 0
`ifdef FSM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic              clk,
    input logic              rst,
    fsm_req_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_FSM);
    localparam int OFF_W = SRC_ID_W + 1;

    logic [NUM_FSM-1:0]  outstanding_q, outstanding_d;
    logic [NUM_FSM-1:0]  arb_won_q, arb_won_d, ack_q, ack_d;
    logic                unmatched_q, unmatched_d;
    logic [PTR_W-1:0]    mem_ptr_q, mem_ptr_d, accel_ptr_q, accel_ptr_d;
    ch_state_e           mem_state_q, mem_state_d, accel_state_q, accel_state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH_W-1:0]  mem_width_q, mem_width_d;
    logic [OPCODE_W-1:0] mem_op_q, mem_op_d, accel_op_q, accel_op_d;
    logic [SRC_ID_W-1:0] mem_src_q, mem_src_d, accel_src_q, accel_src_d;

    logic                mem_free, accel_free;
    logic [NUM_FSM-1:0]  mem_req, accel_req, mem_gnt, accel_gnt;
    logic                mem_gnt_valid, accel_gnt_valid;
    logic [PTR_W-1:0]    mem_gnt_idx, accel_gnt_idx, mem_ptr_next, accel_ptr_next;
    logic [OFF_W-1:0]    resp_off;
    logic [PTR_W-1:0]    resp_idx;
    logic                resp_hit;
    logic [NUM_FSM-1:0]  resp_clr, to_clr;

    // A channel can take a new request when empty or when its current one
    // leaves at this edge. Eligibility uses the registered outstanding bits,
    // so a response clearing FSM i this cycle cannot re-grant i until the next.
    assign mem_free   = (mem_state_q == CH_IDLE) || bus.mem_out_ready;
    assign accel_free = (accel_state_q == CH_IDLE) || bus.accel_out_ready;
    assign mem_req    = bus.fsm_req_valid & bus.fsm_req_is_mem & ~outstanding_q
                        & {NUM_FSM{mem_free}};
    assign accel_req  = bus.fsm_req_valid & ~bus.fsm_req_is_mem & ~outstanding_q
                        & {NUM_FSM{accel_free}};

    fsm_req_arbiter_rr_arbiter #(.NUM_FSM(NUM_FSM)) u_mem_rr (
        .req_i(mem_req), .ptr_i(mem_ptr_q), .gnt_o(mem_gnt),
        .gnt_valid_o(mem_gnt_valid), .gnt_idx_o(mem_gnt_idx), .ptr_next_o(mem_ptr_next)
    );

    fsm_req_arbiter_rr_arbiter #(.NUM_FSM(NUM_FSM)) u_accel_rr (
        .req_i(accel_req), .ptr_i(accel_ptr_q), .gnt_o(accel_gnt),
        .gnt_valid_o(accel_gnt_valid), .gnt_idx_o(accel_gnt_idx), .ptr_next_o(accel_ptr_next)
    );

    // One extra bit so a source_id below BASE_SRC_ID wraps out of range.
    assign resp_off = {1'b0, bus.resp_source_id} - OFF_W'(BASE_SRC_ID);
    assign resp_idx = resp_off[PTR_W-1:0];
    assign resp_hit = bus.resp_valid && (resp_off < OFF_W'(NUM_FSM)) && outstanding_q[resp_idx];
    assign resp_clr = resp_hit ? (NUM_FSM'(1) << resp_idx) : '0;

`ifdef FSM_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0]    to_cnt_q [NUM_FSM];
    logic [TO_W-1:0]    to_cnt_d [NUM_FSM];
    logic [NUM_FSM-1:0] to_fire, timeout_q;

    // A response in the same cycle wins over the timeout.
    always_comb begin
        for (int i = 0; i < NUM_FSM; i++) begin
            to_fire[i]  = outstanding_q[i] && !resp_clr[i]
                          && (to_cnt_q[i] == TO_W'(TIMEOUT_CYCLES - 1));
            to_cnt_d[i] = (outstanding_q[i] && !resp_clr[i] && !to_fire[i])
                          ? to_cnt_q[i] + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= '0;
            for (int i = 0; i < NUM_FSM; i++) to_cnt_q[i] <= '0;
        end else begin
            timeout_q <= to_fire;
            for (int i = 0; i < NUM_FSM; i++) to_cnt_q[i] <= to_cnt_d[i];
        end
    end

    assign to_clr      = to_fire;
    assign bus.timeout = timeout_q;
`else
    assign to_clr = '0;
`endif

    always_comb begin
        mem_state_d   = mem_state_q;
        accel_state_d = accel_state_q;
        mem_ptr_d     = mem_ptr_q;
        accel_ptr_d   = accel_ptr_q;
        mem_addr_d    = mem_addr_q;
        mem_width_d   = mem_width_q;
        mem_op_d      = mem_op_q;
        mem_src_d     = mem_src_q;
        accel_op_d    = accel_op_q;
        accel_src_d   = accel_src_q;
        arb_won_d     = mem_gnt | accel_gnt;
        ack_d         = resp_clr;
        unmatched_d   = unmatched_q || (bus.resp_valid && !resp_hit);
        // Grant needs outstanding = 0 while a clear needs outstanding = 1,
        // so set and clear never target the same FSM.
        outstanding_d = (outstanding_q & ~resp_clr & ~to_clr) | mem_gnt | accel_gnt;

        if (mem_free) begin
            if (mem_gnt_valid) begin
                mem_state_d = CH_BUSY;
                mem_ptr_d   = mem_ptr_next;
                mem_addr_d  = bus.fsm_req_addr[int'(mem_gnt_idx)*ADDR_W +: ADDR_W];
                mem_width_d = bus.fsm_req_width[int'(mem_gnt_idx)*WIDTH_W +: WIDTH_W];
                mem_op_d    = bus.fsm_req_opcode[int'(mem_gnt_idx)*OPCODE_W +: OPCODE_W];
                mem_src_d   = bus.fsm_req_source_id[int'(mem_gnt_idx)*SRC_ID_W +: SRC_ID_W];
            end else begin
                mem_state_d = CH_IDLE;
            end
        end

        if (accel_free) begin
            if (accel_gnt_valid) begin
                accel_state_d = CH_BUSY;
                accel_ptr_d   = accel_ptr_next;
                accel_op_d    = bus.fsm_req_opcode[int'(accel_gnt_idx)*OPCODE_W +: OPCODE_W];
                accel_src_d   = bus.fsm_req_source_id[int'(accel_gnt_idx)*SRC_ID_W +: SRC_ID_W];
            end else begin
                accel_state_d = CH_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            arb_won_q     <= '0;
            ack_q         <= '0;
            unmatched_q   <= 1'b0;
            mem_ptr_q     <= '0;
            accel_ptr_q   <= '0;
            mem_state_q   <= CH_IDLE;
            accel_state_q <= CH_IDLE;
            mem_addr_q    <= '0;
            mem_width_q   <= '0;
            mem_op_q      <= '0;
            mem_src_q     <= '0;
            accel_op_q    <= '0;
            accel_src_q   <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            arb_won_q     <= arb_won_d;
            ack_q         <= ack_d;
            unmatched_q   <= unmatched_d;
            mem_ptr_q     <= mem_ptr_d;
            accel_ptr_q   <= accel_ptr_d;
            mem_state_q   <= mem_state_d;
            accel_state_q <= accel_state_d;
            mem_addr_q    <= mem_addr_d;
            mem_width_q   <= mem_width_d;
            mem_op_q      <= mem_op_d;
            mem_src_q     <= mem_src_d;
            accel_op_q    <= accel_op_d;
            accel_src_q   <= accel_src_d;
        end
    end

    assign bus.arb_won             = arb_won_q;
    assign bus.ack                 = ack_q;
    assign bus.unmatched_resp      = unmatched_q;
    assign bus.mem_out_valid       = (mem_state_q == CH_BUSY);
    assign bus.mem_out_addr        = mem_addr_q;
    assign bus.mem_out_width       = mem_width_q;
    assign bus.mem_out_opcode      = mem_op_q;
    assign bus.mem_out_source_id   = mem_src_q;
    assign bus.accel_out_valid     = (accel_state_q == CH_BUSY);
    assign bus.accel_out_opcode    = accel_op_q;
    assign bus.accel_out_source_id = accel_src_q;
    assign bus.mem_ch_state        = mem_state_q;
    assign bus.accel_ch_state      = accel_state_q;
endmodule

// File: tb/tb_fsm_req_arbiter.sv
// Testbench for fsm_req_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model. Downstream transfers
// are checked by a monitor popping per-channel expected queues.
module tb_fsm_req_arbiter;
    import fsm_req_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int WW   = 3;
    localparam int OW   = 2;
    localparam int SW   = 4;
    localparam int BASE = 0;
    localparam int MEW  = AW + WW + OW + SW;
    localparam int AEW  = OW + SW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_req_arbiter_if #(.NUM_FSM(N), .ADDR_W(AW), .WIDTH_W(WW), .OPCODE_W(OW),
                         .SRC_ID_W(SW)) bus ();

    fsm_req_arbiter #(.NUM_FSM(N), .ADDR_W(AW), .WIDTH_W(WW), .OPCODE_W(OW),
                      .SRC_ID_W(SW), .BASE_SRC_ID(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- stimulus variables ----------------
    logic [N-1:0]  s_valid, s_is_mem;
    logic [AW-1:0] s_addr [N];
    logic [WW-1:0] s_width [N];
    logic [OW-1:0] s_op [N];
    logic          s_mem_rdy, s_acc_rdy, s_resp_v;
    logic [SW-1:0] s_resp_sid;

    // ---------------- reference model ----------------
    bit            m_out [N];     // request outstanding per FSM
    int            m_ptr_mem, m_ptr_acc;
    bit            m_busy_mem, m_busy_acc;
    logic [N-1:0]  exp_won, exp_ack;
    logic          exp_unm;
    logic [MEW-1:0] mem_exp_q [$];
    logic [AEW-1:0] acc_exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_out[i] = 1'b0;
        m_ptr_mem  = 0;
        m_ptr_acc  = 0;
        m_busy_mem = 1'b0;
        m_busy_acc = 1'b0;
        exp_won    = '0;
        exp_ack    = '0;
        exp_unm    = 1'b0;
        mem_exp_q.delete();
        acc_exp_q.delete();
    endtask

    // Applies the spec's rules for one clock edge given the driven inputs.
    task automatic model_advance();
        logic [N-1:0]  won, ackv;
        int            idx;
        internal_req_t e;
        won  = '0;
        ackv = '0;
        if (m_busy_mem && s_mem_rdy) m_busy_mem = 1'b0;
        if (m_busy_acc && s_acc_rdy) m_busy_acc = 1'b0;
        if (s_resp_v) begin
            idx = int'(s_resp_sid) - BASE;
            if (idx >= 0 && idx < N && m_out[idx]) ackv[idx] = 1'b1;
            else exp_unm = 1'b1;
        end
        if (!m_busy_mem) begin
            for (int k = 0; k < N; k++) begin
                int f;
                f = (m_ptr_mem + k) % N;
                if (s_valid[f] && s_is_mem[f] && !m_out[f]) begin
                    won[f]      = 1'b1;
                    e.addr      = s_addr[f];
                    e.width     = s_width[f];
                    e.opcode    = s_op[f];
                    e.source_id = SW'(BASE + f);
                    mem_exp_q.push_back(e);
                    m_busy_mem  = 1'b1;
                    m_ptr_mem   = (f + 1) % N;
                    break;
                end
            end
        end
        if (!m_busy_acc) begin
            for (int k = 0; k < N; k++) begin
                int f;
                f = (m_ptr_acc + k) % N;
                if (s_valid[f] && !s_is_mem[f] && !m_out[f]) begin
                    won[f]     = 1'b1;
                    acc_exp_q.push_back({s_op[f], SW'(BASE + f)});
                    m_busy_acc = 1'b1;
                    m_ptr_acc  = (f + 1) % N;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ackv[i]) m_out[i] = 1'b0;
            if (won[i])  m_out[i] = 1'b1;
        end
        exp_won = won;
        exp_ack = ackv;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        bus.fsm_req_valid  = s_valid;
        bus.fsm_req_is_mem = s_is_mem;
        for (int i = 0; i < N; i++) begin
            bus.fsm_req_addr[i*AW +: AW]        = s_addr[i];
            bus.fsm_req_width[i*WW +: WW]       = s_width[i];
            bus.fsm_req_opcode[i*OW +: OW]      = s_op[i];
            bus.fsm_req_source_id[i*SW +: SW]   = SW'(BASE + i);
        end
        bus.mem_out_ready   = s_mem_rdy;
        bus.accel_out_ready = s_acc_rdy;
        bus.resp_valid      = s_resp_v;
        bus.resp_source_id  = s_resp_sid;
    endtask

    task automatic idle_stim();
        s_valid    = '0;
        s_is_mem   = '0;
        s_resp_v   = 1'b0;
        s_resp_sid = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i]  = '0;
            s_width[i] = '0;
            s_op[i]    = '0;
        end
    endtask

    task automatic check_outputs();
        check("arb_won", 32'(bus.arb_won), 32'(exp_won));
        check("ack", 32'(bus.ack), 32'(exp_ack));
        check("unmatched_resp", 32'(bus.unmatched_resp), 32'(exp_unm));
        check("mem_out_valid", 32'(bus.mem_out_valid), 32'(m_busy_mem));
        check("accel_out_valid", 32'(bus.accel_out_valid), 32'(m_busy_acc));
        check("won_ack_overlap", 32'(bus.arb_won & bus.ack), 32'd0);
    endtask

    // Called at a negedge: check state, drive inputs, step model, wait.
    task automatic cycle();
        check_outputs();
        drive_inputs();
        model_advance();
        @(negedge clk);
    endtask

    task automatic req(input int f, input bit is_mem, input logic [AW-1:0] a,
                       input logic [WW-1:0] w, input logic [OW-1:0] op);
        s_valid[f]  = 1'b1;
        s_is_mem[f] = is_mem;
        s_addr[f]   = a;
        s_width[f]  = w;
        s_op[f]     = op;
    endtask

    task automatic resp(input int sid);
        s_resp_v   = 1'b1;
        s_resp_sid = SW'(sid);
    endtask

    // Asserts reset mid-cycle and checks outputs drop without a clock edge.
    task automatic reset_pulse();
        idle_stim();
        drive_inputs();
        #1 rst = 1'b1;
        #1;
        check("rst_arb_won", 32'(bus.arb_won), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_out_valid), 32'd0);
        check("rst_accel_valid", 32'(bus.accel_out_valid), 32'd0);
        check("rst_unmatched", 32'(bus.unmatched_resp), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_out_addr), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        idle_stim();
        s_mem_rdy = 1'b1;
        s_acc_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m_out[i]) begin
                resp(BASE + i);
                cycle();
                s_resp_v = 1'b0;
            end
        end
        repeat (3) cycle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [MEW-1:0] me;
        logic [AEW-1:0] ae;
        #3;
        if (!rst && bus.mem_out_valid && bus.mem_out_ready) begin
            if (mem_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mem_xfer: unexpected transfer addr 0x%0h, expected none", bus.mem_out_addr);
            end else begin
                me = mem_exp_q.pop_front();
                check("mem_payload", 32'({bus.mem_out_addr, bus.mem_out_width,
                      bus.mem_out_opcode, bus.mem_out_source_id}), 32'(me));
            end
        end
        if (!rst && bus.accel_out_valid && bus.accel_out_ready) begin
            if (acc_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL accel_xfer: unexpected transfer sid 0x%0h, expected none", bus.accel_out_source_id);
            end else begin
                ae = acc_exp_q.pop_front();
                check("accel_payload", 32'({bus.accel_out_opcode, bus.accel_out_source_id}), 32'(ae));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int cand [$];
        idle_stim();
        s_mem_rdy = 1'b1;
        s_acc_rdy = 1'b1;
        model_reset();
        drive_inputs();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single mem request, then its response.
        req(0, 1'b1, 10'h055, 3'd3, MEM_OPCODE_READ);
        cycle();
        idle_stim();
        cycle();
        resp(BASE + 0);
        cycle();
        idle_stim();
        repeat (2) cycle();

        // All four request mem: grants 0..3, then a second round after acks.
        for (int i = 0; i < N; i++) req(i, 1'b1, AW'(16 * i + 1), 3'd2, MEM_OPCODE_WRITE_ADDR);
        repeat (5) cycle();
        for (int i = 0; i < N; i++) begin
            resp(BASE + i);
            cycle();
        end
        s_resp_v = 1'b0;
        repeat (5) cycle();
        drain();

        // Mem and accel grants in the same cycle, channels held busy briefly.
        s_mem_rdy = 1'b0;
        s_acc_rdy = 1'b0;
        req(1, 1'b1, 10'h3a1, 3'd1, MEM_OPCODE_READ);
        req(2, 1'b0, 10'h000, 3'd0, ACCEL_OPCODE_WRITE_DATA);
        cycle();
        idle_stim();
        repeat (2) cycle();
        drain();

        // FSM0 keeps valid high after its grant: only one transfer.
        req(0, 1'b1, 10'h2c4, 3'd5, MEM_OPCODE_READ);
        repeat (4) cycle();
        resp(BASE + 0);
        cycle();
        s_resp_v = 1'b0;
        repeat (2) cycle();
        drain();

        // Randomized traffic with only matching responses.
        for (int c = 0; c < 400; c++) begin
            idle_stim();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    req(i, $urandom_range(0, 1) == 1, AW'($urandom), WW'($urandom), OW'($urandom));
            end
            s_mem_rdy = ($urandom_range(0, 9) < 7);
            s_acc_rdy = ($urandom_range(0, 9) < 7);
            cand.delete();
            for (int i = 0; i < N; i++) if (m_out[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 9) < 4)
                resp(BASE + cand[$urandom_range(0, cand.size() - 1)]);
            cycle();
        end
        drain();

        // Response for an FSM with nothing outstanding: sticky error.
        resp(BASE + 3);
        cycle();
        s_resp_v = 1'b0;
        repeat (3) cycle();

        // Reset with two requests in flight, then their late responses.
        s_mem_rdy = 1'b0;
        s_acc_rdy = 1'b0;
        req(1, 1'b1, 10'h111, 3'd4, MEM_OPCODE_READ);
        req(3, 1'b0, 10'h000, 3'd0, ACCEL_OPCODE_WRITE_DATA);
        cycle();
        idle_stim();
        cycle();
        reset_pulse();
        s_mem_rdy = 1'b1;
        s_acc_rdy = 1'b1;
        cycle();
        resp(BASE + 1);
        cycle();
        s_resp_v = 1'b0;
        repeat (2) cycle();

        // Out-of-range source_id.
        reset_pulse();
        cycle();
        resp(7);
        cycle();
        s_resp_v = 1'b0;
        repeat (3) cycle();

        check("mem_q_drained", 32'(mem_exp_q.size()), 32'd0);
        check("accel_q_drained", 32'(acc_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
